// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the register file.
package regfile_pkg;

   localparam int unsigned RF_WIDTH = 32;
   localparam int unsigned RF_DEPTH = 32;

   // Index width for a given register count; never narrower than one bit.
   function automatic int unsigned rf_addr_w(input int unsigned depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/register_word.sv
// One storage row of the register file: WIDTH bits, async active-low clear, write enable.
module register_word #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_wr_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_data;

   // Row storage: cleared at once on reset, loaded on an enabled edge.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_data <= '0;
      end else if (i_wr_en) begin
         r_data <= i_wr_data;
      end
   end

   assign o_data = r_data;

endmodule

// File: rtl/register_file.sv
// Register file: one write port, two registered read ports, optional zero register.
// Build option: define REGISTER_FILE_BYPASS_EN for write-first behaviour on a same-edge
// read/write collision; the default build is read-first.
module register_file
   import regfile_pkg::*;
#(
   parameter int unsigned WIDTH    = RF_WIDTH,
   parameter int unsigned DEPTH    = RF_DEPTH,
   parameter bit          ZERO_REG = 1'b1,
   localparam int unsigned ADDR_W  = rf_addr_w(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              rd_en_a,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic              rd_en_b,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [WIDTH-1:0]  rd_data_a,
   output logic [WIDTH-1:0]  rd_data_b
);

   // DEPTH as an ADDR_W+1 bit value so range checks compare equal widths.
   localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];

   logic             w_wr_hit;
   logic             w_rd_ok_a;
   logic             w_rd_ok_b;
   logic [WIDTH-1:0] w_rows [DEPTH];
   logic [WIDTH-1:0] w_rd_val_a;
   logic [WIDTH-1:0] w_rd_val_b;
   logic [WIDTH-1:0] r_rd_data_a;
   logic [WIDTH-1:0] r_rd_data_b;

   // A write only counts if in range and not aimed at a hardwired zero register.
   assign w_wr_hit  = wr_en && ({1'b0, wr_addr} < DEPTH_C) && !(ZERO_REG && (wr_addr == '0));
   assign w_rd_ok_a = ({1'b0, rd_addr_a} < DEPTH_C) && !(ZERO_REG && (rd_addr_a == '0));
   assign w_rd_ok_b = ({1'b0, rd_addr_b} < DEPTH_C) && !(ZERO_REG && (rd_addr_b == '0));

   for (genvar g = 0; g < DEPTH; g++) begin : g_row
      logic w_row_we;
      assign w_row_we = w_wr_hit && (wr_addr == ADDR_W'(g));

      register_word #(
         .WIDTH (WIDTH)
      ) u_word (
         .i_clk     (clk),
         .i_rst_n   (rst_n),
         .i_wr_en   (w_row_we),
         .i_wr_data (wr_data),
         .o_data    (w_rows[g])
      );
   end

   // Port A read mux; ignored writes never bypass since w_wr_hit excludes them.
   always_comb begin
      w_rd_val_a = '0;
      if (w_rd_ok_a) begin
         w_rd_val_a = w_rows[rd_addr_a];
`ifdef REGISTER_FILE_BYPASS_EN
         if (w_wr_hit && (wr_addr == rd_addr_a)) begin
            w_rd_val_a = wr_data;
         end
`endif
      end
   end

   // Port B read mux, same rules as port A.
   always_comb begin
      w_rd_val_b = '0;
      if (w_rd_ok_b) begin
         w_rd_val_b = w_rows[rd_addr_b];
`ifdef REGISTER_FILE_BYPASS_EN
         if (w_wr_hit && (wr_addr == rd_addr_b)) begin
            w_rd_val_b = wr_data;
         end
`endif
      end
   end

   // Read output registers: load on strobe, otherwise hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data_a <= '0;
         r_rd_data_b <= '0;
      end else begin
         if (rd_en_a) r_rd_data_a <= w_rd_val_a;
         if (rd_en_b) r_rd_data_b <= w_rd_val_b;
      end
   end

   assign rd_data_a = r_rd_data_a;
   assign rd_data_b = r_rd_data_b;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: three instances (default, ZERO_REG=0, DEPTH=20)
// share stimulus; a reference model pushes expected read data to a scoreboard queue.
module tb_register_file;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        wr_en;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic        rd_en_a;
   logic [4:0]  rd_addr_a;
   logic        rd_en_b;
   logic [4:0]  rd_addr_b;
   logic [31:0] rd_a [3];
   logic [31:0] rd_b [3];

   always #5 clk = ~clk;

   register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b1)) u_dut (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_a[0]), .rd_data_b(rd_b[0]));

   register_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1'b0)) u_dut_nz (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_a[1]), .rd_data_b(rd_b[1]));

   register_file #(.WIDTH(32), .DEPTH(20), .ZERO_REG(1'b1)) u_dut_d20 (
      .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b),
      .rd_data_a(rd_a[2]), .rd_data_b(rd_b[2]));

   typedef struct {
      int          step;
      int          inst;
      int          port;
      logic [31:0] exp;
   } exp_t;

   exp_t        sb [$];
   logic [31:0] mem  [3][32];
   logic [31:0] held [3][2];
   int          checks  = 0;
   int          errors  = 0;
   int          step_no = 0;

`ifdef REGISTER_FILE_BYPASS_EN
   localparam bit BYPASS = 1'b1;
`else
   localparam bit BYPASS = 1'b0;
`endif

   function automatic int dep_of(input int i);
      return (i == 2) ? 20 : 32;
   endfunction

   function automatic bit zr_of(input int i);
      return (i != 1);
   endfunction

   function automatic bit accepted(input int i, input bit we, input logic [4:0] wa);
      return we && (int'(wa) < dep_of(i)) && !(zr_of(i) && (wa == 5'd0));
   endfunction

   function automatic logic [31:0] model_rd(input int i, input logic [4:0] a, input bit we,
                                            input logic [4:0] wa, input logic [31:0] wd);
      if (int'(a) >= dep_of(i)) return 32'h0;
      if (zr_of(i) && (a == 5'd0)) return 32'h0;
      if (BYPASS && accepted(i, we, wa) && (wa == a)) return wd;
      return mem[i][a];
   endfunction

   task automatic check_all();
      exp_t        e;
      logic [31:0] obs;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         obs = (e.port == 0) ? rd_a[e.inst] : rd_b[e.inst];
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL step%0d inst%0d port%0d observed %h expected %h",
                   e.step, e.inst, e.port, obs, e.exp);
         end
      end
   endtask

   task automatic push_held();
      for (int i = 0; i < 3; i++) begin
         for (int p = 0; p < 2; p++) begin
            sb.push_back('{step: step_no, inst: i, port: p, exp: held[i][p]});
         end
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 3; i++) begin
         for (int r = 0; r < 32; r++) mem[i][r] = 32'h0;
         held[i][0] = 32'h0;
         held[i][1] = 32'h0;
      end
   endtask

   // One clock of stimulus; expectations formed before the model absorbs the write.
   task automatic step(input bit we, input logic [4:0] wa, input logic [31:0] wd,
                       input bit ea, input logic [4:0] aa, input bit eb, input logic [4:0] ab);
      @(negedge clk);
      wr_en = we; wr_addr = wa; wr_data = wd;
      rd_en_a = ea; rd_addr_a = aa; rd_en_b = eb; rd_addr_b = ab;
      step_no++;
      for (int i = 0; i < 3; i++) begin
         if (ea) held[i][0] = model_rd(i, aa, we, wa, wd);
         if (eb) held[i][1] = model_rd(i, ab, we, wa, wd);
      end
      push_held();
      for (int i = 0; i < 3; i++) begin
         if (accepted(i, we, wa)) mem[i][wa] = wd;
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   initial begin
      rst_n = 1'b0;
      wr_en = 1'b0; wr_addr = '0; wr_data = '0;
      rd_en_a = 1'b0; rd_addr_a = '0; rd_en_b = 1'b0; rd_addr_b = '0;
      model_clear();

      // Outputs held at zero during reset.
      #12;
      push_held();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;

      // Every address reads zero after reset.
      for (int a = 0; a < 32; a++) step(1'b0, 5'd0, 32'h0, 1'b1, 5'(a), 1'b1, 5'(31 - a));

      // Basic write then read on both ports.
      step(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);

      // Zero register, including a same-edge read that must not bypass.
      step(1'b1, 5'd0, 32'h12345678, 1'b1, 5'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);

      // Collision on r7.
      step(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 1'b0, 5'd0);
      step(1'b1, 5'd7, 32'h22222222, 1'b1, 5'd7, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b1, 5'd7);

      // Hold: rd_en_a low for four cycles while r3 changes underneath.
      step(1'b1, 5'd3, 32'hA5A5A5A5, 1'b0, 5'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
      step(1'b1, 5'd3, 32'h5A5A5A5A, 1'b0, 5'd3, 1'b0, 5'd0);
      for (int k = 0; k < 3; k++) step(1'b0, 5'd0, 32'h0, 1'b0, 5'd3, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);

      // Address 25: out of range only for the DEPTH=20 instance, also on a collision.
      step(1'b1, 5'd25, 32'hBADC0DE5, 1'b1, 5'd25, 1'b1, 5'd25);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd25, 1'b1, 5'd25);

      // Mid-operation reset with a write in flight.
      step(1'b1, 5'd9, 32'hCAFEF00D, 1'b0, 5'd0, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);
      #2;
      rst_n = 1'b0;
      wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'hFFFFFFFF;
      rd_en_a = 1'b1; rd_addr_a = 5'd9; rd_en_b = 1'b1; rd_addr_b = 5'd9;
      #1;
      model_clear();
      push_held();
      check_all();
      @(posedge clk);
      #1;
      push_held();
      check_all();
      @(negedge clk);
      rst_n = 1'b1;
      wr_en = 1'b0; rd_en_a = 1'b0; rd_en_b = 1'b0;
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd9);

      // Short random mix.
      for (int k = 0; k < 40; k++) begin
         step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #200000;
      $display("FAIL timeout observed no-finish expected finish");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per register.
REQ-002 SHALL have parameter DEPTH, default 32, number of registers (2..256).
REQ-003 SHALL have parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-004 SHALL derive local ADDR_W = clog2(DEPTH), minimum 1.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 wr_en  input  1  write strobe.
REQ-008 wr_addr  input  ADDR_W  write register index.
REQ-009 wr_data  input  WIDTH  write data.
REQ-010 rd_en_a / rd_en_b  input  1  read strobe, port A / port B.
REQ-011 rd_addr_a / rd_addr_b  input  ADDR_W  read index, port A / port B.
REQ-012 rd_data_a / rd_data_b  output  WIDTH  registered read data, port A / port B.

Function
REQ-013 SHALL write wr_data into register wr_addr on the rising clk edge where wr_en=1.
REQ-014 SHALL ignore writes when wr_addr >= DEPTH.
REQ-015 SHALL ignore writes to register 0 when ZERO_REG=1.
REQ-016 SHALL give one-cycle read latency: rd_data_x after edge N reflects rd_addr_x sampled at edge N when rd_en_x=1.
REQ-017 SHALL hold rd_data_x unchanged on edges where rd_en_x=0.
REQ-018 SHALL return zero for a read of register 0 when ZERO_REG=1.
REQ-019 SHALL return zero for a read when rd_addr_x >= DEPTH.
REQ-020 SHALL operate ports A and B independently; identical addresses on both ports return identical data.
REQ-021 SHALL return data written in cycle N to any read issued in cycle N+1 or later.
REQ-022 Read/write same address, same edge: behaviour SHALL follow REQ-027/REQ-028.

Reset
REQ-023 SHALL clear every register to zero immediately on rst_n=0, regardless of clk.
REQ-024 SHALL drive rd_data_a and rd_data_b to zero while rst_n=0.
REQ-025 SHALL ignore wr_en and rd_en_x while rst_n=0; a write in flight at reset assertion SHALL be discarded.
REQ-026 SHALL accept operations from the first rising edge after rst_n deasserts.

Configuration
REQ-027 With REGISTER_FILE_BYPASS_EN defined: a read on the same edge as an accepted write to the same address SHALL return the new wr_data (write-first).
REQ-028 Without REGISTER_FILE_BYPASS_EN: the same case SHALL return the old register contents (read-first); the new value is visible from the next read.
REQ-029 Bypass SHALL never apply to ignored writes (register 0 with ZERO_REG=1, out-of-range address).

Structure
REQ-030 Package regfile_pkg SHALL hold the default constants RF_WIDTH=32 and RF_DEPTH=32 and an address-width helper function.
REQ-031 SHALL instantiate sub-module register_word (WIDTH-bit storage row with async active-low clear and write enable) once per register; the read mux and bypass logic live in register_file.

Verification
REQ-032 Reset: hold rst_n=0, then release; read all 32 addresses on both ports -> every read returns 0x00000000.
REQ-033 Write/read: write 0xDEADBEEF to r5, then read r5 on A and r5 on B next cycle -> both return 0xDEADBEEF one cycle after the read strobe.
REQ-034 Zero register: write 0x12345678 to r0 with ZERO_REG=1 -> read r0 returns 0; with ZERO_REG=0 -> returns 0x12345678.
REQ-035 Collision: r7=0x11111111, then same edge write 0x22222222 to r7 and read r7 on A -> 0x22222222 with REGISTER_FILE_BYPASS_EN, 0x11111111 without; next read 0x22222222 in both builds.
REQ-036 Hold and range: DEPTH=20, read r3=0xA5A5A5A5 then drop rd_en_a for 4 cycles -> output stays 0xA5A5A5A5; write/read address 25 -> write ignored, read returns 0.
REQ-037 Mid-operation reset: assert rst_n=0 asynchronously between edges after writing r9=0xCAFEF00D -> rd_data outputs drop to 0 at once; read r9 after release returns 0.
